// File: rtl/mic_sched_pkg.sv
// Shared types, sync constants and byte-slice helper for the mic frame scheduler.
// MIC_SCHED_CHECKSUM_EN adds the CHK state to the state type.
package mic_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR0 = 3'd1,
      S_HDR1 = 3'd2,
      S_C1H  = 3'd3,
      S_C1L  = 3'd4,
      S_C2H  = 3'd5,
      S_C2L  = 3'd6
`ifdef MIC_SCHED_CHECKSUM_EN
      , S_CHK = 3'd7
`endif
   } sched_state_t;

   localparam logic [7:0] SYNC_BYTE0 = 8'hA5;
   localparam logic [7:0] SYNC_BYTE1 = 8'h5A;

   // Byte whose MSB sits at bit position msb of a zero-extended sample.
   function automatic logic [7:0] slice_byte(input logic [63:0] s, input int unsigned msb);
      return 8'(s >> (msb - 7));
   endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous sample-pair FIFO; pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module pair_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 wdata,
   output logic [W-1:0]                 rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];
   // A pop in the same cycle frees the slot the push lands in.
   assign do_push = push && (!full || pop);
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/mic_frame_scheduler.sv
// Captures CIC sample pairs on load_n falling edges and streams them as framed
// bytes over valid/ready. MIC_SCHED_CHECKSUM_EN appends an XOR byte per pair.
module mic_frame_scheduler
   import mic_sched_pkg::*;
#(
   parameter int SAMPLE_W   = 32,
   parameter int BYTE_MSB   = 23,
   parameter int FIFO_DEPTH = 4,
   parameter int FRAME_LEN  = 512
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load_n,
   input  logic [SAMPLE_W-1:0]               d_in_1,
   input  logic [SAMPLE_W-1:0]               d_in_2,
   output logic [7:0]                        byte_data,
   output logic                              byte_valid,
   input  logic                              byte_ready,
   output logic                              overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

   localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   sched_state_t              state, adv_state;
   logic                      load_n_q, capture, pop, full, empty;
   logic [2*SAMPLE_W-1:0]     head, shadow;
   logic [SAMPLE_W-1:0]       d1, d2;
   logic [FW-1:0]             frame_cnt;
   logic [7:0]                d1_hi, d1_lo, d2_hi, d2_lo;

   assign capture = !load_n && load_n_q;
   assign pop     = (state == S_IDLE) && !empty;

   pair_fifo #(.W(2*SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (capture),
      .pop   (pop),
      .wdata ({d_in_1, d_in_2}),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign d1    = shadow[2*SAMPLE_W-1:SAMPLE_W];
   assign d2    = shadow[SAMPLE_W-1:0];
   assign d1_hi = slice_byte(64'(d1), BYTE_MSB);
   assign d1_lo = slice_byte(64'(d1), BYTE_MSB - 8);
   assign d2_hi = slice_byte(64'(d2), BYTE_MSB);
   assign d2_lo = slice_byte(64'(d2), BYTE_MSB - 8);

   assign byte_valid = (state != S_IDLE);

   always_comb begin
      byte_data = 8'h00;
      case (state)
         S_HDR0:  byte_data = SYNC_BYTE0;
         S_HDR1:  byte_data = SYNC_BYTE1;
         S_C1H:   byte_data = d1_hi;
         S_C1L:   byte_data = d1_lo;
         S_C2H:   byte_data = d2_hi;
         S_C2L:   byte_data = d2_lo;
`ifdef MIC_SCHED_CHECKSUM_EN
         S_CHK:   byte_data = d1_hi ^ d1_lo ^ d2_hi ^ d2_lo;
`endif
         default: byte_data = 8'h00;
      endcase
   end

   always_comb begin
      adv_state = S_IDLE;
      case (state)
         S_HDR0:  adv_state = S_HDR1;
         S_HDR1:  adv_state = S_C1H;
         S_C1H:   adv_state = S_C1L;
         S_C1L:   adv_state = S_C2H;
         S_C2H:   adv_state = S_C2L;
`ifdef MIC_SCHED_CHECKSUM_EN
         S_C2L:   adv_state = S_CHK;
`endif
         default: adv_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_n_q <= 1'b1;
         overflow <= 1'b0;
      end else begin
         load_n_q <= load_n;
         if (capture && full && !pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         shadow    <= '0;
         frame_cnt <= '0;
      end else if (state == S_IDLE) begin
         if (!empty) begin
            shadow <= head;
            state  <= (frame_cnt == '0) ? S_HDR0 : S_C1H;
         end
      end else if (byte_ready) begin
         state <= adv_state;
         // Returning to IDLE means the pair's last byte was just accepted.
         if (adv_state == S_IDLE)
            frame_cnt <= (frame_cnt == FW'(FRAME_LEN - 1)) ? '0 : frame_cnt + 1'b1;
      end
   end

endmodule
